// File: rtl/fmc120_pkg.sv
// Shared definitions for the FMC120 capture path: state encoding,
// default geometry and the ADC word layout.
package fmc120_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 64;

    // One sample word carries four 16-bit ADC samples, lane 0 in the low bits.
    localparam int ADC_LANES  = 4;
    localparam int ADC_LANE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port sample RAM, single clock, read-first registered read port.
module capture_dpram
    import fmc120_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // The array itself has no reset so it stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered snapshot recorder: rings ADC words into RAM and freezes
// pre_len words before and post_len words from a trigger edge.
module adc_trig_capture
    import fmc120_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic [AW-1:0] pre_len,
    input  logic [AW:0]   post_len,
    input  logic          trig_in,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state,
    output logic [AW-1:0] start_addr,
    output logic [AW:0]   rec_len
);

    state_t        state_q, state_d;
    logic          trig_d, trig_edge, we, arm_go, enter_done;
    logic [AW-1:0] wptr, trig_ptr, fill_cnt, fill_next, pre_eff, done_trig;
    logic [AW:0]   post_cnt, post_next, post_eff, post_min, post_new;
    logic [AW+1:0] len_sum;

    assign trig_edge = trig_in & ~trig_d;
    assign we        = adc_valid & ((state_q == ST_FILL) || (state_q == ST_WAIT_TRIG) ||
                                    (state_q == ST_POST));
    assign arm_go    = arm & ~abort;
    assign fill_next = fill_cnt + 1'b1;
    assign post_next = post_cnt + 1'b1;

    // A record never exceeds the ring, so the post length is trimmed to fit.
    assign post_min = (post_len == '0) ? {{AW{1'b0}}, 1'b1} : post_len;
    assign len_sum  = {2'b00, pre_len} + {1'b0, post_min};
    assign post_new = (len_sum > {2'b01, {AW{1'b0}}}) ?
                      ({1'b1, {AW{1'b0}}} - {1'b0, pre_len}) : post_min;

    // A direct WAIT_TRIG -> DONE jump needs the trigger address before it is registered.
    assign done_trig  = (state_q == ST_WAIT_TRIG) ? wptr : trig_ptr;
    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign state      = state_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_FILL: begin
                busy = 1'b1;
                if (we && (fill_next == pre_eff)) state_d = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                busy = 1'b1;
                if (trig_edge) begin
                    state_d = (adc_valid && (post_eff == {{AW{1'b0}}, 1'b1})) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                busy = 1'b1;
                if (we && (post_next == post_eff)) state_d = ST_DONE;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        if (arm_go) state_d = (pre_len == '0) ? ST_WAIT_TRIG : ST_FILL;
        if (abort)  state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            trig_d     <= 1'b0;
            wptr       <= '0;
            trig_ptr   <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            pre_eff    <= '0;
            post_eff   <= '0;
            start_addr <= '0;
            rec_len    <= '0;
        end else begin
            state_q <= state_d;
            trig_d  <= trig_in;
            if (arm_go) begin
                wptr     <= '0;
                fill_cnt <= '0;
                post_cnt <= '0;
                pre_eff  <= pre_len;
                post_eff <= post_new;
            end else begin
                if (we) wptr <= wptr + 1'b1;
                if ((state_q == ST_FILL) && we) fill_cnt <= fill_next;
                if ((state_q == ST_WAIT_TRIG) && trig_edge) begin
                    trig_ptr <= wptr;
                    post_cnt <= adc_valid ? {{AW{1'b0}}, 1'b1} : '0;
                end else if ((state_q == ST_POST) && we) begin
                    post_cnt <= post_next;
                end
            end
            if (enter_done) begin
                start_addr <= done_trig - pre_eff;
                rec_len    <= {1'b0, pre_eff} + post_eff;
            end
        end
    end

    capture_dpram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wptr),
        .wdata(adc_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture (AW=6): directed and random captures checked
// against a sample-history model of the trigger/record rules.
module tb_adc_trig_capture;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] pre_len = '0;
    logic [AW:0]   post_len = '0;
    logic          trig_in = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [2:0]    state;
    logic [AW-1:0] start_addr;
    logic [AW:0]   rec_len;

    int errors = 0;
    int checks = 0;
    int cnt = 0;

    // Model: history of words accepted since the last arm plus trigger bookkeeping.
    logic [DW-1:0] hist [$];
    bit   m_busy = 0, m_done = 0, m_trigd = 0, m_trig_prev = 0;
    int   m_pre = 0, m_post = 0, m_trig_n = 0, m_start = 0, m_len = 0;
    logic [2:0] exp_state = 3'd0;

    adc_trig_capture #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .pre_len   (pre_len),
        .post_len  (post_len),
        .trig_in   (trig_in),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .state     (state),
        .start_addr(start_addr),
        .rec_len   (rec_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        int p;
        rise = trig_in && !m_trig_prev;
        m_trig_prev = trig_in;
        if (abort) begin
            m_busy = 0;
            m_done = 0;
        end else if (arm) begin
            m_busy  = 1;
            m_done  = 0;
            m_trigd = 0;
            m_pre   = int'(pre_len);
            p = (post_len == 0) ? 1 : int'(post_len);
            if (m_pre + p > DEPTH) p = DEPTH - m_pre;
            m_post = p;
            hist.delete();
        end else if (m_busy) begin
            if (!m_trigd && rise && hist.size() >= m_pre) begin
                m_trigd  = 1;
                m_trig_n = hist.size();
            end
            if (adc_valid) hist.push_back(adc_data);
            if (m_trigd && (hist.size() - m_trig_n >= m_post)) begin
                m_busy  = 0;
                m_done  = 1;
                m_start = (m_trig_n - m_pre) % DEPTH;
                m_len   = m_pre + m_post;
            end
        end
        if (!m_busy)                   exp_state = m_done ? 3'd4 : 3'd0;
        else if (m_trigd)              exp_state = 3'd3;
        else if (hist.size() < m_pre)  exp_state = 3'd1;
        else                           exp_state = 3'd2;
    endtask

    task automatic check_output();
        check("state", state, exp_state);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("start_addr", start_addr, 64'(m_start));
        check("rec_len", rec_len, 64'(m_len));
    endtask

    task automatic apply_stimulus(input bit v, input bit t, input bit a, input bit ab);
        adc_valid = v;
        trig_in   = t;
        arm       = a;
        abort     = ab;
        adc_data  = {$urandom(), 32'(cnt)};
        cnt++;
        model_step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic read_record(input string tag);
        int base;
        base = m_trig_n - m_pre;
        for (int i = 0; i < m_len; i++) begin
            rd_addr = AW'((m_start + i) % DEPTH);
            apply_stimulus(0, 0, 0, 0);
            check({tag, " word"}, rd_data, hist[base + i]);
        end
    endtask

    task automatic run_capture(input int pre, input int post, input int mode,
                               input int trig_at, input string tag);
        pre_len  = AW'(pre);
        post_len = (AW+1)'(post);
        apply_stimulus(0, 0, 1, 0);
        for (int k = 1; k <= 600 && !m_done; k++) begin
            bit v;
            bit t;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : ($urandom_range(0, 3) != 0);
            t = (k >= trig_at) && (k % 8 == 0);
            apply_stimulus(v, t, 0, 0);
        end
        check({tag, " done"}, done, 1);
        check({tag, " rec_len"}, rec_len, 64'(m_len));
        read_record(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset state", state, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset start_addr", start_addr, 0);
        check("reset rec_len", rec_len, 0);
        check("reset rd_data", rd_data, 0);
        rst = 1'b0;

        // Trigger activity while idle must leave the RAM untouched.
        dut.u_ram.mem[0] = 64'hDEAD;
        rd_addr = '0;
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0);
        check("idle trig state", state, 0);
        check("idle no write", rd_data, 64'hDEAD);

        // pre 8 / post 16, trigger on data value 100.
        cnt = 50;
        pre_len  = 6'd8;
        post_len = 7'd16;
        apply_stimulus(0, 0, 1, 0);
        for (int k = 0; k < 200 && !m_done; k++) apply_stimulus(1, (cnt == 100), 0, 0);
        check("basic done", done, 1);
        check("basic rec_len", rec_len, 24);
        check("basic start_addr", start_addr, 41);
        read_record("basic");
        rd_addr = 6'd41;
        apply_stimulus(0, 0, 0, 0);
        check("basic first value", rd_data[31:0], 92);

        // Clamped record covering the whole ring.
        run_capture(60, 20, 0, 70, "clamp");
        check("clamp rec_len", rec_len, 64);

        // Edges in FILL (including the completion cycle) are ignored.
        pre_len  = 6'd10;
        post_len = 7'd5;
        apply_stimulus(0, 0, 1, 0);
        for (int k = 1; k <= 100 && !m_done; k++) begin
            apply_stimulus(1, (k == 3) || (k >= 10 && k <= 12) || (k == 16), 0, 0);
        end
        check("fill edge done", done, 1);
        check("fill edge start_addr", start_addr, 5);
        read_record("fill edge");

        // Minimal record with gapped data; trigger lands on an invalid cycle.
        run_capture(0, 0, 1, 1, "single");
        check("single rec_len", rec_len, 1);

        // Abort in POST, then arm+abort together from idle and from busy.
        pre_len  = 6'd4;
        post_len = 7'd20;
        apply_stimulus(0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) apply_stimulus(1, (k == 6), 0, 0);
        check("pre abort state", state, 3);
        apply_stimulus(1, 0, 0, 1);
        check("abort state", state, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        apply_stimulus(1, 0, 1, 1);
        check("arm+abort idle state", state, 0);
        apply_stimulus(0, 0, 1, 0);
        repeat (3) apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 1, 1);
        check("arm+abort busy state", state, 0);
        check("arm+abort busy flag", busy, 0);
        run_capture(5, 7, 2, 10, "after abort");

        // Arm while busy restarts the capture.
        pre_len  = 6'd6;
        post_len = 7'd3;
        apply_stimulus(0, 0, 1, 0);
        repeat (4) apply_stimulus(1, 0, 0, 0);
        run_capture(3, 4, 0, 5, "rearm");

        for (int r = 0; r < 4; r++) begin
            run_capture($urandom_range(0, 63), $urandom_range(0, 70), 2,
                        $urandom_range(1, 40), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
